hilo_muldiv_ctrl: RTL
=====================

Name: hilo_muldiv_ctrl

Overview:
Multiply/divide sequencer that owns all writes into the HI/LO register pair. It executes MULT/MULTU as a fixed-latency multi-cycle multiply and DIV/DIVU as an iterative radix-2 divide. MTHI/MTLO pass through with zero latency. It drives we_hi/we_lo/wd_hi/wd_lo of the HI/LO register file and raises busy so the pipeline can stall.

Parameters:
MUL_CYCLES, 2, cycles from multiply acceptance to the write cycle (legal range 1..8)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
op_valid  input  1  issuing stage presents an op this cycle
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
src_a  input  32  rs operand (dividend / multiplicand / MT data)
src_b  input  32  rt operand (divisor / multiplier)
cancel  input  1  flush from exception/branch logic, abort in-flight op
busy  output  1  unit occupied, new mul/div not accepted
we_hi  output  1  write enable to HI
we_lo  output  1  write enable to LO
wd_hi  output  32  HI write data
wd_lo  output  32  LO write data

Behaviour:
- Reset: is synchronous. It forces state IDLE, clears the counter and result registers, and holds busy=0, we_hi=we_lo=0, wd_hi=wd_lo=0 on the cycle after the reset edge.
- Reset mid-operation: discards the in-flight op with no write.
- States: IDLE, MUL, DIV, WB. busy = (state != IDLE), combinational from state.
- Acceptance: an op is accepted only in IDLE with op_valid=1 and cancel=0. In other states op_valid is ignored; the pipeline must hold the op while busy.
- MTHI/MTLO in IDLE:
  - Write is combinational in the same cycle: we_hi (or we_lo) =1, wd = src_a.
  - No state change; busy stays 0.
- Op 11x: no effect.
- MULT/MULTU accepted at cycle T:
  - Capture operands and signedness.
  - 64-bit product: signed for MULT, unsigned for MULTU.
  - MUL state for MUL_CYCLES-1 cycles. With MUL_CYCLES=1, go directly to WB.
  - WB occurs at cycle T+MUL_CYCLES.
- DIV/DIVU accepted at cycle T:
  - Capture |a| and |b| for DIV (raw values for DIVU), plus the sign flags.
  - DIV state runs 32 restoring iterations, one quotient bit per cycle (cycles T+1..T+32). A 6-bit counter is used.
  - WB occurs at cycle T+33.
  - Signed fixup in WB: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0x00000000; no trap.
  - Divisor zero (DIV or DIVU): lo=0xFFFFFFFF, hi=src_a as captured. Same 33-cycle latency.
- WB: lasts exactly one cycle.
  - we_hi=we_lo=1, wd_hi = product[63:32] or remainder, wd_lo = product[31:0] or quotient.
  - Next state is IDLE; an op may be accepted on the following cycle.
  - busy is 1 during WB.
- wd_hi/wd_lo drive 0 whenever the corresponding we is 0.
- cancel in IDLE: blocks acceptance and suppresses MT writes.
- cancel in MUL/DIV/WB:
  - we_hi/we_lo are gated low combinationally that cycle.
  - State returns to IDLE at the next edge; no partial write ever occurs.
- cancel and rst together: rst dominates, with an identical outcome.
- At most one op is in flight; there is no queueing.

Test Plan:
1. MULT a=0xFFFFFFFE, b=3 at T -> at T+2 we_hi=we_lo=1, wd_hi=0xFFFFFFFF, wd_lo=0xFFFFFFFA; busy=1 at T+1..T+2, 0 at T+3. MULTU with the same operands -> wd_hi=0x00000002, wd_lo=0xFFFFFFFA.
2. DIV a=0xFFFFFFF9 (-7), b=2 at T -> writes only at T+33: wd_lo=0xFFFFFFFD, wd_hi=0xFFFFFFFF. DIVU with the same operands -> wd_lo=0x7FFFFFFC, wd_hi=0x00000001.
3. Corner divides:
   - DIVU 5/0 -> wd_hi=0x00000005, wd_lo=0xFFFFFFFF at T+33.
   - DIV 0x80000000/0xFFFFFFFF -> wd_lo=0x80000000, wd_hi=0x00000000.
4. MTHI src_a=0x12345678 in IDLE -> same cycle we_hi=1, wd_hi=0x12345678, we_lo=0, wd_lo=0, busy stays 0. While busy in DIV, the same op_valid -> no write.
5. cancel at T+10 of a DIV -> no we at any cycle, busy=0 at T+11. A MULT presented at T+11 is accepted and writes at T+13.
6. rst asserted at T+5 of a DIV -> busy=0, we=0, wd=0 from T+6. A subsequent DIVU 100/7 gives wd_lo=14, wd_hi=2 at its own T+33.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Sequencer that owns every write into the HI/LO register pair.
//   MULT/MULTU: fixed-latency multiply (write at acceptance + MUL_CYCLES).
//   DIV/DIVU  : 32-step restoring divide (write at acceptance + 33).
//   MTHI/MTLO : zero-latency pass-through write while idle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op_valid, op    issued op (000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                   100 MTHI, 101 MTLO, 11x no-op)
//   src_a, src_b    rs / rt operands
//   cancel          flush; aborts in-flight op, blocks acceptance
//   busy            unit occupied (state != IDLE)
//   we_hi/we_lo     HI/LO write enables
//   wd_hi/wd_lo     HI/LO write data (0 when the matching enable is low)
module hilo_muldiv_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        we_hi,
    output logic        we_lo,
    output logic [31:0] wd_hi,
    output logic [31:0] wd_lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_t;

    // Last counter value spent in MUL before moving to WB.
    localparam logic [5:0] MUL_LAST = 6'((MUL_CYCLES >= 2) ? MUL_CYCLES - 2 : 0);

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] hi_res;   // product high half, or partial remainder
    logic [31:0] lo_res;   // product low half, or dividend/quotient shifter
    logic [31:0] dvs;      // |divisor|
    logic [31:0] a_raw;    // dividend as issued, returned in HI on divide-by-zero
    logic        is_div, neg_q, neg_r, dz;

    logic        accept, sgn;
    logic [63:0] ext_a, ext_b, product;
    logic [31:0] abs_a, abs_b;
    logic [32:0] shifted, diff;
    logic [31:0] q_fix, r_fix, wb_hi, wb_lo;
    logic        mt_ok;

    assign accept = (state == IDLE) && op_valid && !cancel && !rst;
    assign sgn    = ~op[0];

    // Sign- or zero-extend to 64 bits; the truncated 64x64 product is then
    // correct for both signed and unsigned multiplies.
    assign ext_a   = {{32{sgn & src_a[31]}}, src_a};
    assign ext_b   = {{32{sgn & src_b[31]}}, src_b};
    assign product = ext_a * ext_b;

    assign abs_a = (sgn && src_a[31]) ? -src_a : src_a;
    assign abs_b = (sgn && src_b[31]) ? -src_b : src_b;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract; a borrow (diff[32]) means restore and shift in a 0.
    assign shifted = {hi_res, lo_res[31]};
    assign diff    = shifted - {1'b0, dvs};

    assign q_fix = neg_q ? -lo_res : lo_res;
    assign r_fix = neg_r ? -hi_res : hi_res;
    assign wb_hi = is_div ? (dz ? a_raw : r_fix) : hi_res;
    assign wb_lo = is_div ? (dz ? 32'hFFFF_FFFF : q_fix) : lo_res;

    assign busy  = (state != IDLE);
    assign mt_ok = (state == IDLE) && op_valid && !cancel && !rst && (op[2:1] == 2'b10);
    assign we_hi = ((state == WB) && !cancel && !rst) || (mt_ok && !op[0]);
    assign we_lo = ((state == WB) && !cancel && !rst) || (mt_ok &&  op[0]);
    assign wd_hi = !we_hi ? 32'd0 : ((state == WB) ? wb_hi : src_a);
    assign wd_lo = !we_lo ? 32'd0 : ((state == WB) ? wb_lo : src_a);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            hi_res <= 32'd0;
            lo_res <= 32'd0;
            dvs    <= 32'd0;
            a_raw  <= 32'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !op[2]) begin
                        cnt <= 6'd0;
                        if (op[1]) begin
                            hi_res <= 32'd0;
                            lo_res <= abs_a;
                            dvs    <= abs_b;
                            a_raw  <= src_a;
                            neg_q  <= sgn & (src_a[31] ^ src_b[31]);
                            neg_r  <= sgn & src_a[31];
                            dz     <= (src_b == 32'd0);
                            is_div <= 1'b1;
                            state  <= DIV;
                        end else begin
                            // Product is latched at acceptance; MUL only
                            // models the fixed latency.
                            {hi_res, lo_res} <= product;
                            is_div <= 1'b0;
                            state  <= (MUL_CYCLES <= 1) ? WB : MUL;
                        end
                    end
                end
                MUL: begin
                    if (cancel)
                        state <= IDLE;
                    else if (cnt == MUL_LAST)
                        state <= WB;
                    else
                        cnt <= cnt + 6'd1;
                end
                DIV: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        hi_res <= diff[32] ? shifted[31:0] : diff[31:0];
                        lo_res <= {lo_res[30:0], ~diff[32]};
                        cnt    <= cnt + 6'd1;
                        if (cnt == 6'd31)
                            state <= WB;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
